// File: rtl/riscv_alu_pkg.sv
// Shared ALUOp codes and execute-FSM state encoding for the ALU decoder,
// control unit and alu_multicycle_exec.
package riscv_alu_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
   localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
   localparam logic [OP_W-1:0] ALU_XOR = 4'd2;
   localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
   localparam logic [OP_W-1:0] ALU_AND = 4'd4;
   localparam logic [OP_W-1:0] ALU_SLL = 4'd5;
   localparam logic [OP_W-1:0] ALU_SRL = 4'd6;
   localparam logic [OP_W-1:0] ALU_MUL = 4'd7;
   localparam logic [OP_W-1:0] ALU_DIV = 4'd8;
   localparam logic [OP_W-1:0] ALU_NA  = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/alu_multicycle_exec_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Divider registers exist only when ALU_MULTICYCLE_DIV_EN is defined.
module alu_iter_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] q
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] w_mul_next;

   assign w_mul_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign done       = r_busy && (r_cnt == CNT_W'(WIDTH - 1));

`ifdef ALU_MULTICYCLE_DIV_EN
   logic             r_is_div;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_diff;
   logic             w_fits;
   logic [WIDTH-1:0] w_quo_next;
   logic [WIDTH-1:0] w_rem_next;

   // Remainder is always < divisor, so one extra bit is enough to see the borrow.
   assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
   assign w_diff     = w_rem_sh - {1'b0, r_divisor};
   assign w_fits     = !w_diff[WIDTH];
   assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};
   assign w_rem_next = w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
   assign q          = r_is_div ? w_quo_next : w_mul_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_is_div  <= 1'b0;
         r_quo     <= '0;
         r_rem     <= '0;
         r_divisor <= '0;
      end else if (start) begin
         r_is_div  <= is_div;
         r_quo     <= a;
         r_rem     <= '0;
         r_divisor <= b;
      end else if (r_busy) begin
         r_quo     <= w_quo_next;
         r_rem     <= w_rem_next;
      end
   end
`else
   logic w_unused_is_div;
   assign w_unused_is_div = is_div;
   assign q               = w_mul_next;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= a;
         r_mplier <= b;
      end else if (r_busy) begin
         r_busy   <= !done;
         r_cnt    <= done ? '0 : r_cnt + CNT_W'(1);
         r_acc    <= w_mul_next;
         r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
         r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/alu_multicycle_exec.sv
// Execute-stage ALU with valid/ready handshakes: single-cycle ops plus iterative MUL/DIV.
// Define ALU_MULTICYCLE_DIV_EN to build the divider; otherwise code 8 is illegal.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for a request
// BUSY    | MUL/DIV iterating, one bit per cycle
// DONE    | out_valid=1, result held until out_ready
module alu_multicycle_exec #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  alu_op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);
   import riscv_alu_pkg::*;

   localparam int SH_W = $clog2(WIDTH);

   alu_state_t       r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_illegal;

   logic             w_accept;
   logic             w_div_op;
   logic             w_iter;
   logic             w_done;
   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_single;
   logic             w_illegal;

   assign w_accept = in_valid && r_in_ready;
`ifdef ALU_MULTICYCLE_DIV_EN
   assign w_div_op = (alu_op == ALU_DIV);
`else
   assign w_div_op = 1'b0;
`endif
   // Divide-by-zero is answered in one cycle, so only nonzero divisors iterate.
   assign w_iter = (alu_op == ALU_MUL) || (w_div_op && (op_b != '0));

   always_comb begin
      w_single  = '0;
      w_illegal = 1'b0;
      case (alu_op)
         ALU_ADD: w_single = op_a + op_b;
         ALU_SUB: w_single = op_a - op_b;
         ALU_XOR: w_single = op_a ^ op_b;
         ALU_OR:  w_single = op_a | op_b;
         ALU_AND: w_single = op_a & op_b;
         ALU_SLL: w_single = op_a << op_b[SH_W-1:0];
         ALU_SRL: w_single = op_a >> op_b[SH_W-1:0];
         ALU_MUL: w_single = '0;
`ifdef ALU_MULTICYCLE_DIV_EN
         ALU_DIV: w_single = '1;
`endif
         default: w_illegal = 1'b1;
      endcase
   end

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (w_accept && w_iter),
      .is_div (w_div_op),
      .a      (op_a),
      .b      (op_b),
      .done   (w_done),
      .q      (w_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b1;
         r_illegal   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_accept) begin
               r_in_ready <= 1'b0;
               if (w_iter) begin
                  r_state <= ST_BUSY;
               end else begin
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= w_single;
                  r_zero      <= (w_single == '0);
                  r_illegal   <= w_illegal;
               end
            end
            ST_BUSY: if (w_done) begin
               r_state     <= ST_DONE;
               r_out_valid <= 1'b1;
               r_result    <= w_q;
               r_zero      <= (w_q == '0);
               r_illegal   <= 1'b0;
            end
            ST_DONE: if (out_ready) begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_multicycle_exec.sv
// Scoreboard bench for alu_multicycle_exec: driver pushes expected responses,
// a negedge monitor compares every presented output and its latency.
module tb_alu_multicycle_exec;
   import riscv_alu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   alu_op = 4'd0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic         zero;
   logic         illegal;

   typedef struct {
      logic [W-1:0] res;
      logic         zero;
      logic         ill;
      int           acc_cyc;
      int           lat;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   first_cyc = 0;
   bit   seen = 1'b0;

   alu_multicycle_exec #(.WIDTH(W), .OP_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         seen = 1'b0;
      end else if (out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%h required=no_output", result);
         end else begin
            if (!seen) begin
               seen = 1'b1;
               first_cyc = cyc;
               chk({sb[0].name, "_latency"}, W'(first_cyc - sb[0].acc_cyc), W'(sb[0].lat));
            end
            chk({sb[0].name, "_result"}, result, sb[0].res);
            chk({sb[0].name, "_zero"}, W'(zero), W'(sb[0].zero));
            chk({sb[0].name, "_illegal"}, W'(illegal), W'(sb[0].ill));
            if (out_ready) begin
               void'(sb.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] res, input logic ill,
                        input int lat, input bit push);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL %s_accept_timeout actual=in_ready_low required=in_ready_high", name);
      end else begin
         in_valid = 1'b1;
         alu_op   = op;
         op_a     = a;
         op_b     = b;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         if (push) sb.push_back('{res, (res == '0), ill, cyc, lat, name});
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", W'(in_ready), W'(1));
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_result", result, '0);
      chk("rst_zero", W'(zero), W'(1));
      chk("rst_illegal", W'(illegal), W'(0));
      rst = 1'b0;

      issue("add_5_7", ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 0, 1'b1);
      issue("sub_9_9", ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b0, 0, 1'b1);
      issue("sll_shamt5", ALU_SLL, 32'd1, 32'h25, 32'h20, 1'b0, 0, 1'b1);
      issue("xor", ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 0, 1'b1);
      issue("or", ALU_OR, 32'h0000_00A0, 32'h0000_0005, 32'h0000_00A5, 1'b0, 0, 1'b1);
      issue("and", ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 0, 1'b1);
      issue("srl_shamt31", ALU_SRL, 32'h8000_0000, 32'h3F, 32'h1, 1'b0, 0, 1'b1);
      issue("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0, 1'b1);

      issue("mul_ffff_2", ALU_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, W, 1'b1);
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         chk("mul_busy_in_ready", W'(in_ready), W'(0));
         chk("mul_busy_out_valid", W'(out_valid), W'(0));
      end
      issue("mul_1234_5678", ALU_MUL, 32'h1234, 32'h5678, 32'h0626_0060, 1'b0, W, 1'b1);
      issue("mul_zero", ALU_MUL, 32'd0, 32'd5, 32'd0, 1'b0, W, 1'b1);

`ifdef ALU_MULTICYCLE_DIV_EN
      issue("div_100_7", ALU_DIV, 32'd100, 32'd7, 32'd14, 1'b0, W, 1'b1);
      issue("div_big_3", ALU_DIV, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 1'b0, W, 1'b1);
      issue("div_by_zero", ALU_DIV, 32'd55, 32'd0, 32'hFFFF_FFFF, 1'b0, 0, 1'b1);
`else
      issue("div_disabled", ALU_DIV, 32'd100, 32'd7, 32'd0, 1'b1, 0, 1'b1);
      issue("div0_disabled", ALU_DIV, 32'd55, 32'd0, 32'd0, 1'b1, 0, 1'b1);
`endif
      issue("op12_illegal", 4'd12, 32'd3, 32'd4, 32'd0, 1'b1, 0, 1'b1);
      issue("op15_illegal", ALU_NA, 32'd3, 32'd4, 32'd0, 1'b1, 0, 1'b1);
      drain();

      out_ready = 1'b0;
      issue("add_hold", ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_in_ready", W'(in_ready), W'(0));
         in_valid = 1'b1;
         alu_op   = ALU_ADD;
         op_a     = 32'd100;
         op_b     = 32'd100;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      issue("add_after_hold", ALU_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 0, 1'b1);
      drain();

      issue("mul_aborted", ALU_MUL, 32'd3, 32'd5, 32'd15, 1'b0, W, 1'b0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_out_valid", W'(out_valid), W'(0));
      chk("abort_in_ready", W'(in_ready), W'(1));
      chk("abort_result", result, '0);
      chk("abort_zero", W'(zero), W'(1));
      rst = 1'b0;
      issue("add_1_1", ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 0, 1'b1);
      drain();
      repeat (40) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
